score_ram_arbiter: RTL

//  Shares the single-port 32x16 score RAM between three requesters:
//    0 = score update FSM, 1 = leaderboard retrieve, 2 = ID/admin path.

---
 rtl/score_ram_arbiter_if.sv | 31 +++
 rtl/score_ram_arbiter.sv | 134 +++++++++++++
 2 files changed

// File: rtl/score_ram_arbiter_if.sv
// Bundle between the score RAM arbiter, its three requesters and the RAM pins.
// stateDbg exposes the arbiter FSM state (0 = IDLE, 1 = WAIT, 2 = DONE).
interface score_ram_arbiter_if;
    // Handshake: a requester raises req[i] with its req_rw/req_addr/req_wdata fields
    // valid and holds them until done[i]; gnt[i] marks ownership, and done[i] is a
    // one-cycle completion pulse with rdata valid in that cycle.
    logic [2:0]  req;
    logic [2:0]  req_rw;
    logic [14:0] req_addr;
    logic [47:0] req_wdata;
    logic [2:0]  gnt;
    logic [2:0]  done;
    logic [15:0] rdata;
    logic        err;
    logic        busy;
    logic        ram_RW;
    logic [4:0]  ram_Addr;
    logic [15:0] ram_Din;
    logic [15:0] ram_Dout;
    logic [1:0]  stateDbg;

    modport master (
        output req, req_rw, req_addr, req_wdata, ram_Dout,
        input  gnt, done, rdata, err, busy, ram_RW, ram_Addr, ram_Din, stateDbg
    );

    modport slave (
        input  req, req_rw, req_addr, req_wdata, ram_Dout,
        output gnt, done, rdata, err, busy, ram_RW, ram_Addr, ram_Din, stateDbg
    );
endinterface

// File: rtl/score_ram_arbiter.sv
// Round-robin, fixed-latency arbiter sharing the 32x16 score RAM among three requesters.
// Optional write protection below PROT_ADDR for requesters 0/1: define SCORE_ARB_WPROT_EN.
module score_ram_arbiter #(
    parameter int LAT       = 3,
    parameter int PROT_ADDR = 0
) (
    input logic               clk,
    input logic               rst,
    score_ram_arbiter_if.slave bus
);

`ifdef SCORE_ARB_WPROT_EN
    localparam bit WPROT = 1'b1;
`else
    localparam bit WPROT = 1'b0;
`endif

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } stateT;

    stateT       state;
    logic [3:0]  cnt;
    logic [1:0]  rrPtr;
    logic [1:0]  ownerIdx;
    logic        rejReg;
    logic [2:0]  gnt;
    logic [2:0]  done;
    logic [15:0] rdata;
    logic        err;
    logic        ramRW;
    logic [4:0]  ramAddr;
    logic [15:0] ramDin;

    logic [2:0]  elig;
    logic        anyElig;
    logic [1:0]  winIdx;
    logic [4:0]  selAddr;
    logic [15:0] selData;
    logic        selRw;
    logic        wprotHit;

    // done masks the requester whose level is still high in the cycle after completion
    always_comb begin
        elig    = bus.req & ~done;
        anyElig = |elig;
        case (rrPtr)
            2'd1:    winIdx = elig[1] ? 2'd1 : (elig[2] ? 2'd2 : 2'd0);
            2'd2:    winIdx = elig[2] ? 2'd2 : (elig[0] ? 2'd0 : 2'd1);
            default: winIdx = elig[0] ? 2'd0 : (elig[1] ? 2'd1 : 2'd2);
        endcase
        case (winIdx)
            2'd1: begin
                selAddr = bus.req_addr[9:5];
                selData = bus.req_wdata[31:16];
                selRw   = bus.req_rw[1];
            end
            2'd2: begin
                selAddr = bus.req_addr[14:10];
                selData = bus.req_wdata[47:32];
                selRw   = bus.req_rw[2];
            end
            default: begin
                selAddr = bus.req_addr[4:0];
                selData = bus.req_wdata[15:0];
                selRw   = bus.req_rw[0];
            end
        endcase
        wprotHit = WPROT && selRw && (winIdx != 2'd2) && (int'(selAddr) < PROT_ADDR);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= 4'd0;
            rrPtr    <= 2'd0;
            ownerIdx <= 2'd0;
            rejReg   <= 1'b0;
            gnt      <= 3'd0;
            done     <= 3'd0;
            rdata    <= 16'd0;
            err      <= 1'b0;
            ramRW    <= 1'b0;
            ramAddr  <= 5'd0;
            ramDin   <= 16'd0;
        end else begin
            done <= 3'd0;
            err  <= 1'b0;
            case (state)
                IDLE: begin
                    ramRW <= 1'b0;
                    if (anyElig) begin
                        gnt      <= 3'b001 << winIdx;
                        ownerIdx <= winIdx;
                        ramAddr  <= selAddr;
                        ramDin   <= selData;
                        ramRW    <= selRw && !wprotHit;
                        rejReg   <= wprotHit;
                        cnt      <= 4'd0;
                        state    <= WAIT;
                    end
                end
                WAIT: begin
                    cnt <= cnt + 4'd1;
                    if (cnt == 4'(LAT - 1)) state <= DONE;
                end
                DONE: begin
                    // a rejected write ran as a read, so it also refreshes rdata
                    if (!ramRW) rdata <= bus.ram_Dout;
                    done  <= gnt;
                    err   <= rejReg;
                    gnt   <= 3'd0;
                    ramRW <= 1'b0;
                    rrPtr <= (ownerIdx == 2'd2) ? 2'd0 : ownerIdx + 2'd1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.gnt      = gnt;
    assign bus.done     = done;
    assign bus.rdata    = rdata;
    assign bus.err      = err;
    assign bus.busy     = (state != IDLE);
    assign bus.ram_RW   = ramRW;
    assign bus.ram_Addr = ramAddr;
    assign bus.ram_Din  = ramDin;
    assign bus.stateDbg = state;

endmodule
